spart_tx: RTL and testbench
===========================

Name: spart_tx

Overview:
- DUT-side SPART transmitter: accepts bytes from the processor-side bus and serialises them onto txd as 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1.
- Sits opposite the serial bench model that samples txd.
- Double-buffered: one holding register plus one shift register, so the CPU can queue the next byte while the current frame is on the line.

Parameters:
- DATA_W, 8, data bits per frame; only 8 is supported.
- BAUD_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- baud  input  BAUD_W  divisor; each bit lasts baud+1 clk cycles
- wr_en  input  1  write strobe from bus decode; sampled on rising clk
- wr_data  input  8  byte to transmit
- tbr  output  1  transmit buffer ready; holding register empty
- tx_busy  output  1  frame in progress (state != IDLE)
- ovr  output  1  one-cycle pulse when wr_en arrives while tbr=0
- txd  output  1  serial line, registered, idles high

Behaviour:
- Reset values (asynchronous, also mid-frame):
  - txd=1, tbr=1, tx_busy=0, ovr=0
  - hold register empty, state IDLE, bit counter 0, baud counter 0
  - any partial frame is abandoned; the line returns to mark immediately.
- Holding register:
  - wr_en with tbr=1 captures wr_data at that edge; tbr=0 from the next cycle.
  - wr_en with tbr=0: data dropped, hold register unchanged, ovr=1 for exactly one cycle.
- Transfer:
  - Occurs when the hold register is full and either state is IDLE, or state is STOP and its final baud cycle is reached.
  - Hold register moves to the shift register, state goes to START, tbr returns to 1, all in the same edge.
- Baud counter:
  - Loaded with the current baud value at entry to every bit, then decrements each clk.
  - A bit ends on the cycle the counter reads 0.
  - baud is re-sampled per bit; a change mid-frame affects only subsequent bits.
  - baud=0 gives 1 clk per bit.
- State machine (enum IDLE, START, DATA, STOP, plus PARITY when enabled):
  - IDLE: txd=1; go to START on transfer.
  - START: txd=0 for baud+1 cycles, then DATA with bit counter 0.
  - DATA: txd=shift[0] for each bit; shift right at bit end; bit counter increments. After bit 7 (counter 7 at bit end) go to STOP (or PARITY).
  - STOP: txd=1 for baud+1 cycles, then START if hold is full (back-to-back, no idle gap), else IDLE.
- Latency: wr_en at edge N in IDLE with hold empty → hold full after N → transfer at N+1 → txd=0 from N+1. tbr is low for exactly one cycle.
- Frame length: 10*(baud+1) cycles (11*(baud+1) with parity).
- Simultaneous events:
  - wr_en on the same edge as a transfer: tbr is still 0 at that edge, so the write is dropped and ovr pulses.
  - A write on the next edge is accepted.
- txd is driven from a flop, never combinationally from state.

Optional Feature:
- Macro SPART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP; txd = XOR of the 8 data bits (even parity) for baud+1 cycles; frame is 11 bits.
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Decomposition:
- Package spart_pkg:
  - tx_state_t enum
  - SPART_DATA_W=8
  - SPART_START_BIT=1'b0, SPART_STOP_BIT=1'b1
  - frame-length localparams for the bench
- Sub-module spart_baud_cnt:
  - Loadable down-counter.
  - Inputs: load, baud.
  - Output: bit_end, asserted when count==0 and not loading.
  - Intended for reuse by the future spart_rx.

Test Plan:
- Single byte: baud=3, write 8'hA5 in IDLE → txd=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; tbr low 1 cycle; tx_busy high 40 cycles.
- Back-to-back: baud=1, write 8'h0F, then write 8'hF0 once tbr=1 → second start bit immediately follows the first stop bit with no idle cycle; total 40 cycles busy.
- Overrun: queue 8'h11 while 8'h22 is sending; write 8'h33 with tbr=0 → ovr pulses 1 cycle; wire shows 8'h22 then 8'h11; 8'h33 never appears.
- baud=0: write 8'h80 → each bit exactly 1 cycle; txd sequence 0,0,0,0,0,0,0,0,1,1.
- Reset mid-frame: assert rst_n low during DATA bit 3 → txd=1, tbr=1, tx_busy=0 asynchronously; after release, a new write of 8'h55 sends a clean frame.
- SPART_TX_PARITY_EN defined: 8'h07 → parity bit 1, 11-bit frame; 8'h03 → parity bit 0.

Source files
------------

// File: rtl/spart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_pkg                                                            |
// | Shared types and frame constants for the SPART serial blocks.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spart_pkg;

   localparam int   SPART_DATA_W    = 8;
   localparam logic SPART_START_BIT = 1'b0;
   localparam logic SPART_STOP_BIT  = 1'b1;

`ifdef SPART_TX_PARITY_EN
   localparam int SPART_FRAME_BITS = 11;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } tx_state_t;
`else
   localparam int SPART_FRAME_BITS = 10;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
   } tx_state_t;
`endif

   // Clock cycles occupied by one frame for a given divisor.
   function automatic int spart_frame_cycles(input int baud);
      return SPART_FRAME_BITS * (baud + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_baud_cnt                                                       |
// | Loadable bit-time down-counter; reloads itself at every bit end.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spart_baud_cnt #(
   parameter int BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_load,
   input  logic [BAUD_W-1:0] i_baud,
   output logic              o_bit_end
);

   logic [BAUD_W-1:0] r_cnt;

   assign o_bit_end = i_en && (r_cnt == '0) && !i_load;

   // A bit ending is the entry to the next one, so the divisor is re-sampled there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load || o_bit_end) begin
         r_cnt <= i_baud;
      end else if (i_en) begin
         r_cnt <= r_cnt - 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_tx                                                             |
// | Double-buffered 8N1 serial transmitter (hold + shift register).      |
// | Optional even parity bit: define SPART_TX_PARITY_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spart_tx
   import spart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BAUD_W-1:0] i_baud,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_tbr,
   output logic              o_tx_busy,
   output logic              o_ovr,
   output logic              o_txd
);

   localparam logic [2:0] c_LAST_BIT = 3'(DATA_W - 1);

   tx_state_t         r_state, w_state_nxt;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic [2:0]        r_bit, w_bit_nxt;
   logic              r_txd, w_txd_nxt;
   logic              r_ovr;
   logic              w_bit_end;
   logic              w_load;
   logic              w_xfer;
`ifdef SPART_TX_PARITY_EN
   logic              r_par;
`endif

   assign w_load = (r_state == ST_IDLE) && r_hold_full;
   assign w_xfer = w_load || ((r_state == ST_STOP) && w_bit_end && r_hold_full);

   spart_baud_cnt #(
      .BAUD_W (BAUD_W)
   ) u_baud_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (r_state != ST_IDLE),
      .i_load    (w_load),
      .i_baud    (i_baud),
      .o_bit_end (w_bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // txd is computed for the next state so the flop presents it with the state change.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_txd_nxt   = r_txd;
      case (r_state)
         ST_IDLE: begin
            w_txd_nxt = SPART_STOP_BIT;
            if (w_xfer) begin
               w_state_nxt = ST_START;
               w_shift_nxt = r_hold;
               w_txd_nxt   = SPART_START_BIT;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_nxt = ST_DATA;
               w_bit_nxt   = '0;
               w_txd_nxt   = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == c_LAST_BIT) begin
`ifdef SPART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
                  w_txd_nxt   = r_par;
`else
                  w_state_nxt = ST_STOP;
                  w_txd_nxt   = SPART_STOP_BIT;
`endif
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
                  w_txd_nxt = r_shift[1];
               end
            end
         end
`ifdef SPART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = ST_STOP;
               w_txd_nxt   = SPART_STOP_BIT;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_end) begin
               if (w_xfer) begin
                  w_state_nxt = ST_START;
                  w_shift_nxt = r_hold;
                  w_txd_nxt   = SPART_START_BIT;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_txd_nxt   = SPART_STOP_BIT;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = SPART_STOP_BIT;
         end
      endcase
   end

   // A transfer needs a full hold register, so it never coincides with an accepted write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_bit       <= '0;
         r_txd       <= SPART_STOP_BIT;
         r_ovr       <= 1'b0;
      end else begin
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_txd   <= w_txd_nxt;
         r_ovr   <= i_wr_en && r_hold_full;
         if (w_xfer) begin
            r_hold_full <= 1'b0;
         end else if (i_wr_en && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold      <= i_wr_data;
         end
      end
   end

`ifdef SPART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= 1'b0;
      end else if (w_xfer) begin
         r_par <= ^r_hold;
      end
   end
`endif

   assign o_tbr     = !r_hold_full;
   assign o_tx_busy = (r_state != ST_IDLE);
   assign o_ovr     = r_ovr;
   assign o_txd     = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spart_tx                                                          |
// | Directed self-checking bench for spart_tx.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spart_tx;

   localparam int FB   = spart_pkg::SPART_FRAME_BITS;
   localparam int MAXC = 128;

   logic        clk;
   logic        rst_n;
   logic [15:0] baud;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        tbr;
   logic        tx_busy;
   logic        ovr;
   logic        txd;

   int n_chk;
   int n_pass;

   logic cap_txd  [MAXC];
   logic cap_busy [MAXC];
   logic cap_ovr  [MAXC];
   logic cap_tbr  [MAXC];
   logic exp_txd  [MAXC];
   logic exp_busy [MAXC];
   logic exp_ovr  [MAXC];

   spart_tx #(
      .DATA_W (8),
      .BAUD_W (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_baud    (baud),
      .i_wr_en   (wr_en),
      .i_wr_data (wr_data),
      .o_tbr     (tbr),
      .o_tx_busy (tx_busy),
      .o_ovr     (ovr),
      .o_txd     (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_txd[i]  = txd;
         cap_busy[i] = tx_busy;
         cap_ovr[i]  = ovr;
         cap_tbr[i]  = tbr;
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < MAXC; i++) begin
         exp_txd[i]  = 1'b1;
         exp_busy[i] = 1'b0;
         exp_ovr[i]  = 1'b0;
      end
   endtask

   // Lay one frame into the expectation arrays starting at cycle s.
   task automatic add_frame(input int s, input logic [7:0] d, input logic par, input int b);
      logic bv;
      for (int k = 0; k < FB; k++) begin
         if (k == 0)                 bv = 1'b0;
         else if (k <= 8)            bv = d[k-1];
         else if (FB == 11 && k == 9) bv = par;
         else                        bv = 1'b1;
         for (int c = 0; c <= b; c++) begin
            exp_txd[s + k*(b+1) + c]  = bv;
            exp_busy[s + k*(b+1) + c] = 1'b1;
         end
      end
   endtask

   task automatic compare(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_txd[%0d]", tag, i), 32'(cap_txd[i]), 32'(exp_txd[i]));
         chk($sformatf("%s_busy[%0d]", tag, i), 32'(cap_busy[i]), 32'(exp_busy[i]));
         chk($sformatf("%s_ovr[%0d]", tag, i), 32'(cap_ovr[i]), 32'(exp_ovr[i]));
      end
   endtask

   // One byte from idle: write at cycle 0, start bit from cycle 2.
   task automatic single(input string tag, input logic [7:0] d, input logic par, input int b);
      int n;
      n    = 2 + FB*(b+1) + 3;
      baud = 16'(b);
      clear_exp();
      add_frame(2, d, par, b);
      fork
         capture(n);
         begin
            @(negedge clk); wr_en = 1'b1; wr_data = d;
            @(negedge clk); wr_en = 1'b0;
         end
      join
      compare(tag, n);
      chk({tag, "_tbr0"}, 32'(cap_tbr[0]), 32'd1);
      chk({tag, "_tbr1"}, 32'(cap_tbr[1]), 32'd0);
      chk({tag, "_tbr2"}, 32'(cap_tbr[2]), 32'd1);
   endtask

   initial begin
      int n;
      n_chk   = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      baud    = 16'd3;
      #12;
      chk("rst_txd",  32'(txd),     32'd1);
      chk("rst_tbr",  32'(tbr),     32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_ovr",  32'(ovr),     32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      single("a5", 8'hA5, 1'b0, 3);

      // Back-to-back: second byte queued as soon as tbr returns high.
      baud = 16'd1;
      n    = 2 + 2*FB*2 + 3;
      clear_exp();
      add_frame(2, 8'h0F, 1'b0, 1);
      add_frame(2 + FB*2, 8'hF0, 1'b0, 1);
      fork
         capture(n);
         begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h0F;
            @(negedge clk); wr_en = 1'b0;
            @(negedge clk); wr_en = 1'b1; wr_data = 8'hF0;
            @(negedge clk); wr_en = 1'b0;
         end
      join
      compare("b2b", n);
      chk("b2b_tbr2", 32'(cap_tbr[2]), 32'd1);
      chk("b2b_tbr3", 32'(cap_tbr[3]), 32'd0);

      // Overrun: 8'h33 arrives while 8'h11 waits behind 8'h22.
      clear_exp();
      add_frame(2, 8'h22, 1'b0, 1);
      add_frame(2 + FB*2, 8'h11, 1'b0, 1);
      exp_ovr[4] = 1'b1;
      fork
         capture(n);
         begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h22;
            @(negedge clk); wr_en = 1'b0;
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h11;
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h33;
            @(negedge clk); wr_en = 1'b0;
         end
      join
      compare("ovr", n);

      // Write on the transfer edge is dropped; the following edge accepts.
      clear_exp();
      add_frame(2, 8'h44, 1'b0, 1);
      add_frame(2 + FB*2, 8'h77, 1'b0, 1);
      exp_ovr[2] = 1'b1;
      fork
         capture(n);
         begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h44;
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h66;
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h77;
            @(negedge clk); wr_en = 1'b0;
         end
      join
      compare("sim", n);

      single("b0", 8'h80, 1'b1, 0);

      // Asynchronous reset during DATA bit 3 of 8'hA5 with 8'hC3 queued.
      baud = 16'd3;
      @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
      @(negedge clk); wr_en = 1'b0;
      @(negedge clk); wr_en = 1'b1; wr_data = 8'hC3;
      @(negedge clk); wr_en = 1'b0;
      repeat (16) @(negedge clk);
      chk("pre_rst_txd",  32'(txd),     32'd0);
      chk("pre_rst_tbr",  32'(tbr),     32'd0);
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_txd",  32'(txd),     32'd1);
      chk("arst_tbr",  32'(tbr),     32'd1);
      chk("arst_busy", 32'(tx_busy), 32'd0);
      chk("arst_ovr",  32'(ovr),     32'd0);
      @(negedge clk); rst_n = 1'b1;

      single("p55", 8'h55, 1'b0, 2);
      single("p07", 8'h07, 1'b1, 2);
      single("p03", 8'h03, 1'b0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
